// File: rtl/rom_seq_reader.sv
// Address sequencer and read-out register in front of an asynchronous ROM, with a valid/ready output stream.
// Optional running checksum port enabled by defining ROM_SEQ_READER_CSUM_EN.
module rom_seq_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef ROM_SEQ_READER_CSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] csum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] remaining;
    logic                  xfer_c;
    logic                  load_c;

    // A word leaves on transfer; the output register can be refilled when empty or emptying.
    assign xfer_c = out_valid && out_ready;
    assign load_c = (state == RUN) && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rom_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef ROM_SEQ_READER_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        rom_addr  <= base_addr;
                        remaining <= len;
`ifdef ROM_SEQ_READER_CSUM_EN
                        csum      <= '0;
`endif
                    end
                end
                RUN: begin
                    if (load_c) begin
                        out_data  <= rom_q;
                        out_valid <= 1'b1;
                        if (remaining == '0) begin
                            state <= DRAIN;
                        end else begin
                            rom_addr  <= rom_addr + ADDR_WIDTH'(1);
                            remaining <= remaining - ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (xfer_c) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
`ifdef ROM_SEQ_READER_CSUM_EN
            // Accumulate every word the consumer accepts; cleared only by an accepted start.
            if (xfer_c) begin
                csum <= csum + out_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rom_seq_reader.sv
// Self-checking bench for rom_seq_reader: transaction-level scoreboard model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_rom_seq_reader;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] len       = '0;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] out_data;
    logic [DW-1:0] csum;

    logic [DW-1:0] mem [DEPTH];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    rom_seq_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ROM_SEQ_READER_CSUM_EN
        ,
        .csum      (csum)
`endif
    );

`ifndef ROM_SEQ_READER_CSUM_EN
    assign csum = '0;
`endif

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(8'hA0 + i);
    end
    assign rom_q = mem[rom_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: words still owed to the consumer, how many have been presented so far.
    bit            m_active = 0;
    bit            m_valid  = 0;
    bit            m_done   = 0;
    int            m_n      = 0;
    int            m_pres   = 0;
    logic [AW-1:0] m_base   = '0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_csum   = '0;
    logic [DW-1:0] exp_q[$];

    logic [DW-1:0] xfer_log[$];
    int            xfer_cyc[$];
    int            done_cyc[$];
    logic [DW-1:0] done_csum[$];
    logic [AW-1:0] addr_log[$];

    function automatic logic [AW-1:0] addr_now();
        int off;
        off = (m_pres < m_n) ? m_pres : m_n - 1;
        return AW'(int'(m_base) + off);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_active = 0; m_valid = 0; m_done = 0; m_n = 0; m_pres = 0;
            m_addr = '0; m_csum = '0; exp_q.delete();
        end else begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("rom_addr", 32'(rom_addr), 32'(m_addr));
`ifdef ROM_SEQ_READER_CSUM_EN
            chk("csum", 32'(csum), 32'(m_csum));
`endif
            if (m_valid) begin
                if (exp_q.size() > 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
                else begin
                    tests++; fails++;
                    $display("FAIL out_data: got %0h expected no word (cycle %0d)", out_data, cyc);
                end
            end
            if (busy && (addr_log.size() == 0 || addr_log[$] != rom_addr)) addr_log.push_back(rom_addr);
            if (done) begin
                done_cyc.push_back(cyc);
                done_csum.push_back(csum);
            end
            // Predict what the next edge produces.
            m_done = 0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_valid = 0; m_pres = 0;
                    m_n = int'(len) + 1; m_base = base_addr; m_csum = '0;
                    exp_q.delete();
                    for (int i = 0; i < m_n; i++) exp_q.push_back(mem[(int'(base_addr) + i) % int'(DEPTH)]);
                    m_addr = addr_now();
                end
            end else if (m_valid && out_ready) begin
                xfer_log.push_back(out_data);
                xfer_cyc.push_back(cyc);
                if (exp_q.size() > 0) begin
                    m_csum = m_csum + exp_q[0];
                    void'(exp_q.pop_front());
                end
                if (m_pres >= m_n) begin
                    m_active = 0; m_valid = 0; m_done = 1;
                end else begin
                    m_pres++;
                    m_addr = addr_now();
                end
            end else if (!m_valid) begin
                m_valid = 1;
                m_pres++;
                m_addr = addr_now();
            end
        end
    end

    task automatic clear_logs();
        xfer_log.delete(); xfer_cyc.delete(); done_cyc.delete(); done_csum.delete(); addr_log.delete();
    endtask

    task automatic start_xfer(input logic [AW-1:0] b, input logic [AW-1:0] l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int t = 0;
        while (done_cyc.size() < n && t < budget) begin
            @(posedge clk); t++;
        end
        if (done_cyc.size() < n) begin
            tests++; fails++;
            $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cyc.size(), n);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_addr"}, 32'(rom_addr), 32'h0);
        chk({tag, "_data"}, 32'(out_data), 32'h0);
`ifdef ROM_SEQ_READER_CSUM_EN
        chk({tag, "_csum"}, 32'(csum), 32'h0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] wrap_exp [4];
        logic [AW-1:0] wrap_addr [4];
        bit            bp_pat [7];
        int            t;
        wrap_exp  = '{8'hA6, 8'hA7, 8'hA0, 8'hA1};
        wrap_addr = '{3'd6, 3'd7, 3'd0, 3'd1};
        bp_pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        repeat (2) @(posedge clk); #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // Full sweep
        clear_logs();
        start_xfer(3'd0, 3'd7);
        wait_done(1, 40);
        chk("sweep_count", 32'(xfer_log.size()), 32'd8);
        if (xfer_log.size() == 8 && done_cyc.size() == 1) begin
            for (int i = 0; i < 8; i++) chk("sweep_word", 32'(xfer_log[i]), 32'(8'hA0 + i));
            chk("sweep_consecutive", 32'(xfer_cyc[7] - xfer_cyc[0]), 32'd7);
            chk("sweep_done_latency", 32'(done_cyc[0] - xfer_cyc[7]), 32'd1);
`ifdef ROM_SEQ_READER_CSUM_EN
            chk("sweep_csum", 32'(done_csum[0]), 32'h1C);
`endif
        end

        // Wrap
        clear_logs();
        start_xfer(3'd6, 3'd3);
        wait_done(1, 40);
        chk("wrap_count", 32'(xfer_log.size()), 32'd4);
        chk("wrap_addr_count", 32'(addr_log.size()), 32'd4);
        if (xfer_log.size() == 4 && addr_log.size() == 4 && done_cyc.size() == 1) begin
            for (int i = 0; i < 4; i++) begin
                chk("wrap_word", 32'(xfer_log[i]), 32'(wrap_exp[i]));
                chk("wrap_addr", 32'(addr_log[i]), 32'(wrap_addr[i]));
            end
`ifdef ROM_SEQ_READER_CSUM_EN
            chk("wrap_csum", 32'(done_csum[0]), 32'h8E);
`endif
        end

        // Backpressure
        clear_logs();
        start_xfer(3'd0, 3'd3);
        for (int i = 0; i < 7; i++) begin
            out_ready = bp_pat[i];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done(1, 40);
        chk("bp_count", 32'(xfer_log.size()), 32'd4);
        chk("bp_done_count", 32'(done_cyc.size()), 32'd1);
        if (xfer_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("bp_word", 32'(xfer_log[i]), 32'(8'hA0 + i));

        // Start while busy is ignored
        clear_logs();
        start_xfer(3'd0, 3'd7);
        repeat (2) @(posedge clk);
        start_xfer(3'd5, 3'd2);
        wait_done(1, 40);
        repeat (10) @(posedge clk);
        chk("busy_start_count", 32'(xfer_log.size()), 32'd8);
        chk("busy_start_done_count", 32'(done_cyc.size()), 32'd1);
        if (xfer_log.size() == 8)
            for (int i = 0; i < 8; i++) chk("busy_start_word", 32'(xfer_log[i]), 32'(8'hA0 + i));

        // Reset mid-transfer
        clear_logs();
        start_xfer(3'd0, 3'd7);
        t = 0;
        while (xfer_log.size() < 3 && t < 40) begin
            @(posedge clk); t++;
        end
        chk("rst_reached_third_word", 32'(xfer_log.size()), 32'd3);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("midrst");
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("midrst_no_done", 32'(done_cyc.size()), 32'd0);
        clear_logs();
        start_xfer(3'd2, 3'd0);
        wait_done(1, 20);
        chk("post_rst_count", 32'(xfer_log.size()), 32'd1);
        if (xfer_log.size() == 1) chk("post_rst_word", 32'(xfer_log[0]), 32'hA2);

        // Back-to-back with start held through done
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 3'd3; len = 3'd0;
        t = 0;
        while (done_cyc.size() < 1 && t < 50) begin
            @(posedge clk); t++;
        end
        #1 start = 1'b0;
        wait_done(2, 30);
        chk("b2b_count", 32'(xfer_log.size()), 32'd2);
        if (xfer_log.size() == 2 && done_cyc.size() == 2) begin
            chk("b2b_word0", 32'(xfer_log[0]), 32'hA3);
            chk("b2b_word1", 32'(xfer_log[1]), 32'hA3);
            chk("b2b_restart_gap", 32'(xfer_cyc[1] - done_cyc[0]), 32'd2);
`ifdef ROM_SEQ_READER_CSUM_EN
            chk("b2b_csum0", 32'(done_csum[0]), 32'hA3);
            chk("b2b_csum1", 32'(done_csum[1]), 32'hA3);
`endif
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rom_seq_reader.md
# rom_seq_reader

Address sequencer and read-out stage that sits directly upstream of the asynchronous single-port ROM. On a start command it sweeps a contiguous, wrapping address range and drives `rom_addr`. It captures the combinational `rom_q` into an output register and presents each word on a valid/ready stream. It signals completion with a one-cycle `done` pulse.

## Interface
- `DATA_WIDTH`, default 8: ROM word width; also the width of `out_data` and `csum`.
- `ADDR_WIDTH`, default 3: ROM address width; the ROM depth is 2**ADDR_WIDTH.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a transfer; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first address; sampled with `start`.
- `len`  in  ADDR_WIDTH  word count minus one (0 means 1 word, all-ones means the full ROM); sampled with `start`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse after the final word is accepted.
- `rom_addr`  out  ADDR_WIDTH  address to the ROM; registered.
- `rom_q`  in  DATA_WIDTH  ROM data; combinational from `rom_addr`.
- `out_data`  out  DATA_WIDTH  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready from the consumer.
- `csum`  out  DATA_WIDTH  running checksum; present only with ROM_SEQ_READER_CSUM_EN.

## Operation
- States are IDLE, RUN and DRAIN.
- **IDLE → RUN**
  - Occurs on the first edge with `start`=1.
  - Loads `rom_addr`←`base_addr` and `remaining`←`len`.
  - Clears `csum`.
- **Load condition in RUN:** the output register is free, i.e. `!out_valid || out_ready`.
- **On each load in RUN:**
  - `out_data`←`rom_q`, `out_valid`←1.
  - If `remaining`==0, go to DRAIN.
  - Otherwise `rom_addr`←`rom_addr`+1 modulo 2**ADDR_WIDTH, and `remaining`←`remaining`−1.
- **When the load condition is false:** hold `rom_addr`, `remaining` and `out_data` unchanged.
- **Handshake:**
  - A word is transferred on any edge with `out_valid && out_ready`.
  - `out_data` must not change while `out_valid`=1 and `out_ready`=0.
  - If no new load occurs on the transfer edge, `out_valid`←0.
- **DRAIN → IDLE**
  - Occurs on the edge where the last word transfers; that edge also clears `out_valid`.
  - `done`←1 for exactly one cycle.
- **Start handling:**
  - `start` is ignored in RUN and DRAIN; there is no queuing.
  - A `start` asserted in the same cycle that `done` is high is accepted, because the block is then in IDLE.
- **Address wrap:** wrapping past 2**ADDR_WIDTH−1 to 0 is legal and silent.
- **No truncation:** `len` is ADDR_WIDTH bits wide, so a transfer never exceeds the ROM depth.
- **Reset:**
  - Assertion of `rst_n`, including mid-transfer, immediately forces IDLE.
  - All outputs go to 0: `busy`, `done`, `rom_addr`, `out_data`, `out_valid` and `csum`.
  - The aborted transfer produces no `done`.

## Timing
- `start` sampled at edge k:
  - `busy`=1 and `rom_addr`=`base_addr` after edge k.
  - First word with `out_valid`=1 after edge k+1.
- Throughput is one word per cycle while `out_ready`=1.
- With constant `out_ready`=1, a transfer of N words has its last word valid after edge k+N and `done` high after edge k+N+1.
- `busy` is exactly `state != IDLE`, registered.
- `rom_addr` changes only on a clock edge. `rom_q` must settle within the same cycle; there is no multicycle path.

## Configuration
- **`ROM_SEQ_READER_CSUM_EN` defined:**
  - The `csum` port exists.
  - `csum` is the sum, modulo 2**DATA_WIDTH, of every word transferred on the stream since the last accepted `start`.
  - It is updated on the transfer edge and is final when `done` is high.
  - It holds its value until the next accepted `start`.
- **`ROM_SEQ_READER_CSUM_EN` undefined:** the `csum` port and its adder are absent; all other behaviour is identical.

## Test plan
- **ROM contents for all scenarios:** mem[i]=8'hA0+i.
- **Full sweep:** `base_addr`=0, `len`=7, `out_ready`=1 → `out_data` A0..A7 on 8 consecutive cycles; `done` is high one cycle after A7 transfers; `csum`=8'h1C.
- **Wrap:** `base_addr`=6, `len`=3 → A6, A7, A0, A1; `rom_addr` sequence 6, 7, 0, 1; `csum`=8'h8E.
- **Backpressure:** `base_addr`=0, `len`=3, `out_ready` pattern 1, 0, 0, 1, 0, 1, 1 → exactly A0..A3 delivered in order, each word held stable while `out_ready`=0, with no duplicates or drops.
- **Start while busy:** second `start` with `base_addr`=5 issued during RUN of a `base_addr`=0, `len`=7 transfer → ignored; only A0..A7 and one `done` pulse.
- **Reset mid-transfer:** `rst_n`=0 after the third word → all outputs 0 immediately and no `done`; a following `start` with `base_addr`=2, `len`=0 → single word A2, then `done`.
- **Back-to-back:** `start` held high through `done` with `len`=0 → a second transfer starts the cycle after `done`; the `csum` of the second transfer covers only its own word.
